// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: turns a signed duty command into pwm/dir outputs with
// once-per-period sampling and a dead-time sequence on every direction reversal.
module motor_pwm_driver #(
  parameter int PERIOD   = 2500,
  parameter int DEADTIME = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [23:0] i_duty,
  input  logic [23:0] i_deadband,
  output logic        o_pwm,
  output logic        o_dir,
  output logic        o_period_start,
  output logic [23:0] o_duty_applied
);

  typedef enum logic [1:0] {RUN, DEAD_PRE, DEAD_POST} state_t;

  localparam logic [23:0] LP_PERIOD = 24'(PERIOD);
  localparam logic [23:0] LP_LAST   = 24'(PERIOD - 1);
  localparam logic [23:0] LP_DEAD1  = 24'(DEADTIME);
  localparam logic [23:0] LP_DEAD2  = 24'(2 * DEADTIME);

  state_t      r_state, w_stateNext;
  logic        r_run;
  logic [23:0] r_cnt, w_cntNext;
  logic [23:0] r_mag, w_magNext;
  logic [23:0] r_dutyApplied, w_dutyAppliedNext;
  logic        r_pwm, w_pwmNext;
  logic        r_dir, w_dirNext;
  logic        r_periodStart;
  logic        w_sample;
  logic [23:0] w_abs, w_clip, w_cmdMag;

  // Commanded magnitude: |duty| with -2^23 saturated, clipped to PERIOD, then deadband/enable.
  always_comb begin
    w_abs = i_duty;
    if (i_duty[23]) begin
      w_abs = (i_duty == 24'h800000) ? 24'h7FFFFF : (~i_duty + 24'd1);
    end
    w_clip   = (w_abs > LP_PERIOD) ? LP_PERIOD : w_abs;
    w_cmdMag = w_clip;
    if (!i_enable || (!i_deadband[23] && (w_clip <= i_deadband))) begin
      w_cmdMag = '0;
    end
  end

  // Values computed here describe the cycle that begins at the next edge, so every output is registered.
  always_comb begin
    w_sample          = r_run && (r_cnt == LP_LAST);
    w_cntNext         = '0;
    w_stateNext       = r_state;
    w_dirNext         = r_dir;
    w_magNext         = r_mag;
    w_dutyAppliedNext = r_dutyApplied;
    if (r_run && (r_cnt != LP_LAST)) begin
      w_cntNext = r_cnt + 24'd1;
    end
    if (w_sample) begin
      w_magNext         = w_cmdMag;
      w_dutyAppliedNext = '0;
      w_stateNext       = RUN;
      if (w_cmdMag != '0) begin
        w_dutyAppliedNext = i_duty[23] ? (~w_cmdMag + 24'd1) : w_cmdMag;
        if (i_duty[23] != r_dir) begin
          if (DEADTIME == 0) begin
            w_dirNext = i_duty[23];
          end else begin
            w_stateNext = DEAD_PRE;
          end
        end
      end
    end else if (!i_enable) begin
      w_magNext   = '0;
      w_stateNext = RUN;
    end else begin
      case (r_state)
        DEAD_PRE: begin
          if (w_cntNext == LP_DEAD1) begin
            w_stateNext = DEAD_POST;
            w_dirNext   = ~r_dir;
          end
        end
        DEAD_POST: begin
          if (w_cntNext == LP_DEAD2) begin
            w_stateNext = RUN;
          end
        end
        default: ;
      endcase
    end
    w_pwmNext = (w_stateNext == RUN) && (w_cntNext < w_magNext);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= RUN;
      r_run         <= 1'b0;
      r_cnt         <= '0;
      r_mag         <= '0;
      r_dutyApplied <= '0;
      r_pwm         <= 1'b0;
      r_dir         <= 1'b0;
      r_periodStart <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_run         <= 1'b1;
      r_cnt         <= w_cntNext;
      r_mag         <= w_magNext;
      r_dutyApplied <= w_dutyAppliedNext;
      r_pwm         <= w_pwmNext;
      r_dir         <= w_dirNext;
      r_periodStart <= (w_cntNext == '0);
    end
  end

  assign o_pwm          = r_pwm;
  assign o_dir          = r_dir;
  assign o_period_start = r_periodStart;
  assign o_duty_applied = r_dutyApplied;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: captures whole PWM periods and
// compares them with a period-level model of the drive rules.
module tb_motor_pwm_driver;

  localparam int P = 2500;
  localparam int D = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] duty;
  logic [23:0] db;
  wire         pwm;
  wire         dir;
  wire         ps;
  wire  [23:0] da;

  int total = 0;
  int bad   = 0;

  bit          obsPwm[P];
  bit          obsDir[P];
  bit          obsPs[P];
  logic [23:0] obsDa0;
  logic [23:0] obsDaLast;

  int mMag;
  bit mDir;
  bit mDirBefore;
  bit mRev;
  int mDa;

  always #5 clk = ~clk;

  motor_pwm_driver #(.PERIOD(P), .DEADTIME(D)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_duty         (duty),
    .i_deadband     (db),
    .o_pwm          (pwm),
    .o_dir          (dir),
    .o_period_start (ps),
    .o_duty_applied (da)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic void modelReset();
    mMag = 0; mDir = 0; mDirBefore = 0; mRev = 0; mDa = 0;
  endfunction

  // Period-level rules: what the next period looks like given the sampled inputs.
  function automatic void modelSample(input logic [23:0] d, input logic [23:0] b, input bit e);
    int sd, sb, m;
    sd = $signed(d);
    sb = $signed(b);
    m  = (sd < 0) ? -sd : sd;
    if (m > 8388607) m = 8388607;
    if (m > P) m = P;
    if (!e || m <= sb) m = 0;
    mDirBefore = mDir;
    mRev = (m > 0) && ((sd < 0) != mDir);
    if (m > 0) mDir = (sd < 0);
    mMag = m;
    mDa  = (m == 0) ? 0 : ((sd < 0) ? -m : m);
  endfunction

  // Number of cycles in the captured period that deviate from the model waveform.
  function automatic int waveErrs(input int offAt, output int firstBad);
    int e;
    bit ep, ed;
    e = 0;
    firstBad = -1;
    for (int c = 0; c < P; c++) begin
      ep = mRev ? (c >= 2 * D && c < mMag) : (c < mMag);
      if (offAt >= 0 && c > offAt) ep = 0;
      ed = (mRev && c < D) ? mDirBefore : mDir;
      if (obsPwm[c] !== ep || obsDir[c] !== ed || obsPs[c] !== (c == 0)) begin
        if (firstBad < 0) firstBad = c;
        e++;
      end
    end
    return e;
  endfunction

  task automatic nextPeriod(input logic [23:0] d, input logic [23:0] b, input bit e);
    duty = d; db = b; en = e;
    modelSample(d, b, e);
  endtask

  task automatic capturePeriod(input int chgAt, input logic [23:0] chgDuty, input bit chgEn);
    for (int c = 0; c < P; c++) begin
      @(negedge clk);
      obsPwm[c] = pwm;
      obsDir[c] = dir;
      obsPs[c]  = ps;
      if (c == 0) obsDa0 = da;
      if (c == P - 1) obsDaLast = da;
      if (c == chgAt) begin
        duty = chgDuty;
        en   = chgEn;
      end
    end
  endtask

  task automatic test_reset();
    int e, fb;
    rst = 1'b1; en = 1'b1; duty = 24'd1250; db = 24'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({pwm, dir, ps} !== 3'b000) begin
      bad++; $display("FAIL reset_bits: pwm/dir/ps=%b required 000", {pwm, dir, ps});
    end
    total++;
    if (da !== 24'd0) begin
      bad++; $display("FAIL reset_duty: duty_applied=%0d required 0", $signed(da));
    end
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) nextPeriod(24'd1250, 24'd0, 1'b1);
      capturePeriod(-1, 24'd0, 1'b1);
      e = waveErrs(-1, fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL reset_wave p%0d: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                        i, e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa)) begin
        bad++; $display("FAIL reset_duty p%0d: duty_applied=%0d required %0d", i, $signed(obsDa0), mDa);
      end
    end
  endtask

  task automatic test_saturation();
    int e, fb;
    int cmds[3] = '{3000, -8388608, -8388608};
    for (int i = 0; i < 3; i++) begin
      nextPeriod(24'(cmds[i]), 24'd0, 1'b1);
      capturePeriod(-1, 24'd0, 1'b1);
      e = waveErrs(-1, fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL sat_wave p%0d: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                        i, e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa)) begin
        bad++; $display("FAIL sat_duty p%0d: duty_applied=%0d required %0d", i, $signed(obsDa0), mDa);
      end
    end
  endtask

  task automatic test_deadband();
    int e, fb;
    int cmds[2] = '{1000, -80};
    int dbs[2]  = '{0, 100};
    for (int i = 0; i < 2; i++) begin
      nextPeriod(24'(cmds[i]), 24'(dbs[i]), 1'b1);
      capturePeriod(-1, 24'd0, 1'b1);
      e = waveErrs(-1, fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL db_wave p%0d: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                        i, e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa)) begin
        bad++; $display("FAIL db_duty p%0d: duty_applied=%0d required %0d", i, $signed(obsDa0), mDa);
      end
    end
  endtask

  task automatic test_midperiod_reversal();
    int e, fb;
    int cmds[3] = '{1000, -1000, -1000};
    for (int i = 0; i < 3; i++) begin
      nextPeriod(24'(cmds[i]), 24'd0, 1'b1);
      if (i == 0) capturePeriod(500, 24'(-1000), 1'b1);
      else        capturePeriod(-1, 24'd0, 1'b1);
      e = waveErrs(-1, fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL rev_wave p%0d: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                        i, e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa)) begin
        bad++; $display("FAIL rev_duty p%0d: duty_applied=%0d required %0d", i, $signed(obsDa0), mDa);
      end
    end
  endtask

  task automatic test_enable();
    int e, fb;
    bit ens[4]    = '{1'b1, 1'b1, 1'b0, 1'b1};
    int chgAt[4]  = '{-1, 300, 1200, -1};
    bit chgEn[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    int offAt[4]  = '{-1, 300, -1, -1};
    for (int i = 0; i < 4; i++) begin
      nextPeriod(24'd1000, 24'd0, ens[i]);
      capturePeriod(chgAt[i], 24'd1000, chgEn[i]);
      e = waveErrs(offAt[i], fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL en_wave p%0d: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                        i, e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa) || obsDaLast !== 24'(mDa)) begin
        bad++; $display("FAIL en_duty p%0d: duty_applied start=%0d end=%0d required %0d",
                        i, $signed(obsDa0), $signed(obsDaLast), mDa);
      end
    end
  endtask

  task automatic test_random();
    int e, fb, kind;
    logic [23:0] d, b;
    bit ee;
    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: d = 24'($urandom_range(0, 3000));
        1: d = 24'(-int'($urandom_range(0, 3000)));
        2: d = 24'($urandom);
        3: d = 24'h800000;
        4: d = 24'h7FFFFF;
        default: d = 24'(int'($urandom_range(0, 300)) - 150);
      endcase
      b  = ($urandom_range(0, 3) == 0) ? 24'(-int'($urandom_range(1, 500))) : 24'($urandom_range(0, 200));
      ee = ($urandom_range(0, 7) != 0);
      nextPeriod(d, b, ee);
      capturePeriod(-1, 24'd0, 1'b1);
      e = waveErrs(-1, fb);
      total++;
      if (e != 0) begin
        bad++; $display("FAIL rnd_wave p%0d duty=%0d db=%0d en=%b: %0d bad cycles, first c=%0d pwm=%b dir=%b, required 0",
                        i, $signed(d), $signed(b), ee, e, fb, obsPwm[fb], obsDir[fb]);
      end
      total++;
      if (obsDa0 !== 24'(mDa)) begin
        bad++; $display("FAIL rnd_duty p%0d: duty_applied=%0d required %0d", i, $signed(obsDa0), mDa);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, fb, n;
    nextPeriod(24'(-2000), 24'd0, 1'b1);
    capturePeriod(-1, 24'd0, 1'b1);
    e = waveErrs(-1, fb);
    total++;
    if (e != 0) begin
      bad++; $display("FAIL rstmid_wave: %0d bad cycles, first c=%0d pwm=%b dir=%b ps=%b, required 0",
                      e, fb, obsPwm[fb], obsDir[fb], obsPs[fb]);
    end
    nextPeriod(24'(-2000), 24'd0, 1'b1);
    for (int c = 0; c <= 600; c++) @(negedge clk);
    total++;
    if ({pwm, dir} !== {(600 < mMag), mDir}) begin
      bad++; $display("FAIL rstmid_pre: pwm/dir=%b required %b", {pwm, dir}, {(600 < mMag), mDir});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({pwm, dir, ps} !== 3'b000 || da !== 24'd0) begin
      bad++; $display("FAIL rstmid_clear: pwm/dir/ps=%b duty_applied=%0d required 000 and 0",
                      {pwm, dir, ps}, $signed(da));
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps !== 1'b1 && n < 4);
    total++;
    if (n != 1 || ps !== 1'b1) begin
      bad++; $display("FAIL rstmid_first_ps: period_start after %0d cycles (ps=%b) required 1 cycle", n, ps);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; duty = 24'd0; db = 24'd0;
    test_reset();
    test_saturation();
    test_deadband();
    test_midperiod_reversal();
    test_enable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
